// File: rtl/sa_ram_rws_param.sv
// Parametrised single-clock RAM with separate read/write ports, byte-masked writes,
// selectable read-during-write behaviour, optional output register and post-reset clear.
module sa_ram_rws_param #(
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int DW         = 128,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra,
  input  logic            re,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  input  logic [AW-1:0]   wa,
  input  logic            we,
  input  logic [DW/8-1:0] wmask,
  input  logic [DW-1:0]   di,
  output logic            init_done,
  input  logic [31:0]     pwrbus_ram_pd
);
  localparam int            NB      = DW/8;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_v1;
  logic [DW-1:0] w_s1;
  logic          w_ready, w_rd_acc, w_wr, w_clr, w_ra_ok;
  logic          w_unused;

  assign w_unused  = ^pwrbus_ram_pd;
  assign w_ready   = (r_state == ST_READY);
  assign init_done = w_ready;
  assign w_rd_acc  = w_ready & re;
  assign w_ra_ok   = ({1'b0, ra} < DEPTH_L);
  // The array has no reset, so port writes and clear writes are held off while rst is high.
  assign w_wr      = w_ready & we & ~rst & ({1'b0, wa} < DEPTH_L);
  assign w_clr     = (r_state == ST_CLEAR) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_state <= ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++)
        if (wmask[i]) r_mem[wa][8*i +: 8] <= di[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_v1 <= 1'b0;
    else     r_v1 <= w_rd_acc;
  end

  generate
    if (RDW_MODE == 0) begin : g_wfirst
      // Address is registered, data read combinationally: later writes to ra_d show through.
      logic [AW-1:0] r_ra_d;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_ra_d <= '0;
        else if (w_rd_acc) r_ra_d <= ra;
      end
      assign w_s1 = ({1'b0, r_ra_d} < DEPTH_L) ? r_mem[r_ra_d] : '0;
    end else begin : g_rfirst
      logic [DW-1:0] r_snap;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_snap <= '0;
        else if (w_rd_acc) r_snap <= w_ra_ok ? r_mem[ra] : '0;
      end
      assign w_s1 = r_snap;
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] r_dout_q;
      logic          r_v2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dout_q <= '0;
          r_v2     <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_dout_q <= w_s1;
        end
      end
      assign dout     = r_dout_q;
      assign dout_vld = r_v2;
    end else begin : g_noreg
      assign dout     = w_s1;
      assign dout_vld = r_v1;
    end
  endgenerate
endmodule
